caliptra_log_fifo_mux: RTL and testbench

// - Multi-channel successor to the single-byte log FIFO tap: captures NUM_CH toggle-strobed log words from generic output wires.
// - Buffers captured words in one shared DEPTH-entry FIFO, tagged with the source channel.
// - Presents the FIFO as a valid/ready stream to the FPGA log path, with per-channel drop counters and a sticky overflow flag.
// - Sits in the FPGA top between caliptra_wrapper_top generic_output_wires and the host-visible log FIFO.
//

---
 rtl/caliptra_log_pkg.sv | 22 ++
 rtl/caliptra_log_rr_arb.sv | 58 +++++
 rtl/caliptra_log_fifo_mux.sv | 168 ++++++++++++++++
 tb/tb_caliptra_log_fifo_mux.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caliptra_log_pkg.sv
// Shared definitions for the multi-channel log FIFO tap.
//   DROP_CNT_W  : width of each per-channel drop counter
//   log_entry_t : one FIFO entry, {source channel, log word}; sized for the
//                 largest supported configuration (8 channels, 32-bit words),
//                 unused upper bits are left zero and trimmed by synthesis
//   ch_w()      : channel index width, never narrower than one bit
package caliptra_log_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int CH_MAX_W   = 3;
    localparam int DATA_MAX_W = 32;

    typedef struct packed {
        logic [CH_MAX_W-1:0]   ch;
        logic [DATA_MAX_W-1:0] data;
    } log_entry_t;

    function automatic int ch_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/caliptra_log_rr_arb.sv
// Round-robin arbiter for the log channels.
//   core_clk, cptra_rst_b : clock, synchronous active-low reset
//   req                   : one request bit per channel (pending words)
//   en                    : a grant may be issued this cycle
//   grant                 : one-hot grant, all zero when nothing is granted
//   grant_idx             : index of the granted channel
//   grant_valid           : a grant is issued this cycle
//   prio_ptr_o            : current highest-priority channel (debug view)
module caliptra_log_rr_arb
    import caliptra_log_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic              core_clk,
    input  logic              cptra_rst_b,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid,
    output logic [CH_W-1:0]   prio_ptr_o
);

    logic [CH_W-1:0] prio_ptr;

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= NUM_CH) ? s - NUM_CH : s;
    endfunction

    // Scan from prio_ptr upward, wrapping; the first requester wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (en && !grant_valid && req[wrap_idx(int'(prio_ptr), i)]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(wrap_idx(int'(prio_ptr), i));
                grant[wrap_idx(int'(prio_ptr), i)] = 1'b1;
            end
        end
    end

    // The channel after the winner gets first chance next time.
    always_ff @(posedge core_clk) begin
        if (!cptra_rst_b) begin
            prio_ptr <= '0;
        end else if (grant_valid) begin
            prio_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign prio_ptr_o = prio_ptr;

endmodule

// File: rtl/caliptra_log_fifo_mux.sv
// Multi-channel log tap: captures toggle-strobed words from NUM_CH channels,
// tags them with their channel and buffers them in one shared FWFT FIFO.
//   core_clk, cptra_rst_b : clock, synchronous active-low reset
//   log_data_i            : channel c word at [c*DATA_W +: DATA_W]
//   log_toggle_i          : bit c flips when channel c presents a new word
//   flush_i               : empties the FIFO and drops all pending words
//   clr_drop_i            : clears drop counters and overflow_o
//   out_valid_o/out_ready_i, out_data_o, out_ch_o : head-of-FIFO stream
//   fill_o                : FIFO occupancy, 0..DEPTH
//   drop_cnt_o            : 16-bit saturating drop count per channel
//   overflow_o            : sticky, set on any drop
// Supports NUM_CH 1..8 and DATA_W up to 32.
//
// Handshake: the head entry is transferred on every cycle where
// out_valid_o and out_ready_i are both high; out_valid_o never drops and
// the head never changes until it has been transferred (or flushed), and
// out_data_o/out_ch_o are meaningless while out_valid_o is low.
module caliptra_log_fifo_mux
    import caliptra_log_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 64,
    localparam int CH_W   = ch_w(NUM_CH),
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int FILL_W = PTR_W + 1
) (
    input  logic                         core_clk,
    input  logic                         cptra_rst_b,
    input  logic [NUM_CH*DATA_W-1:0]     log_data_i,
    input  logic [NUM_CH-1:0]            log_toggle_i,
    input  logic                         flush_i,
    input  logic                         clr_drop_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_W-1:0]            out_data_o,
    output logic [CH_W-1:0]              out_ch_o,
    output logic [FILL_W-1:0]            fill_o,
    output logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt_o,
    output logic                         overflow_o
);

    logic                                 armed;
    logic [NUM_CH-1:0]                    tog_q;
    logic [NUM_CH-1:0]                    evt;
    logic [NUM_CH-1:0]                    pend;
    logic [NUM_CH-1:0]                    grant;
    logic [NUM_CH-1:0]                    drop;
    logic [NUM_CH-1:0][DATA_W-1:0]        hold;
    logic [NUM_CH-1:0][DROP_CNT_W-1:0]    drop_cnt;
    logic                                 overflow_q;
    logic [CH_W-1:0]                      grant_idx;
    logic [CH_W-1:0]                      arb_prio;
    logic                                 push;
    logic                                 pop;
    logic                                 arb_en;
    log_entry_t                           mem [DEPTH];
    log_entry_t                           push_entry;
    log_entry_t                           head;
    logic [PTR_W-1:0]                     wr_ptr;
    logic [PTR_W-1:0]                     rd_ptr;
    logic [FILL_W-1:0]                    fill;
    logic                                 dbg_unused;

    // No events in the arm cycle (tog_q not yet valid) or while flushing.
    assign evt  = (armed && !flush_i) ? (log_toggle_i ^ tog_q) : '0;
    // A granted channel frees its hold register this cycle, so a new word
    // can replace it without loss.
    assign drop = evt & pend & ~grant;

    assign out_valid_o = (fill != '0);
    assign pop         = out_valid_o & out_ready_i;
    assign arb_en      = !flush_i && ((fill != FILL_W'(DEPTH)) || pop);

    caliptra_log_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .core_clk    (core_clk),
        .cptra_rst_b (cptra_rst_b),
        .req         (pend),
        .en          (arb_en),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (push),
        .prio_ptr_o  (arb_prio)
    );

    always_comb begin
        push_entry      = '0;
        push_entry.ch   = CH_MAX_W'(grant_idx);
        push_entry.data = DATA_MAX_W'(hold[grant_idx]);
    end

    // Per-channel capture: toggle tracking, hold register, pending flag.
    always_ff @(posedge core_clk) begin
        if (!cptra_rst_b) begin
            armed <= 1'b0;
            tog_q <= '0;
            pend  <= '0;
            hold  <= '0;
        end else begin
            armed <= 1'b1;
            tog_q <= log_toggle_i;
            for (int c = 0; c < NUM_CH; c++) begin
                if (flush_i) begin
                    pend[c] <= 1'b0;
                end else if (evt[c] && !drop[c]) begin
                    hold[c] <= log_data_i[c*DATA_W +: DATA_W];
                    pend[c] <= 1'b1;
                end else if (grant[c]) begin
                    pend[c] <= 1'b0;
                end
            end
        end
    end

    // Drop accounting; a clear in the same cycle as a drop wins.
    always_ff @(posedge core_clk) begin
        if (!cptra_rst_b || clr_drop_i) begin
            drop_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (drop[c] && (drop_cnt[c] != '1)) begin
                    drop_cnt[c] <= drop_cnt[c] + 1'b1;
                end
            end
            if (|drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge core_clk) begin
        if (!cptra_rst_b || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill <= fill + FILL_W'(push) - FILL_W'(pop);
        end
    end

    always_ff @(posedge core_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head       = mem[rd_ptr];
    assign out_data_o = head.data[DATA_W-1:0];
    assign out_ch_o   = head.ch[CH_W-1:0];
    assign fill_o     = fill;
    assign drop_cnt_o = drop_cnt;
    assign overflow_o = overflow_q;

    // Padding bits of the stored entry and the arbiter debug pointer are
    // intentionally not consumed by any output.
    assign dbg_unused = ^{head, arb_prio};

endmodule

// File: tb/tb_caliptra_log_fifo_mux.sv
module tb_caliptra_log_fifo_mux;

    localparam int NCH   = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    // ---------------- clock / reset / DUT ----------------
    logic          core_clk = 1'b0;
    logic          cptra_rst_b;
    logic [15:0]   log_data_i;
    logic [1:0]    log_toggle_i;
    logic          flush_i;
    logic          clr_drop_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [7:0]    out_data_o;
    logic [0:0]    out_ch_o;
    logic [2:0]    fill_o;
    logic [31:0]   drop_cnt_o;
    logic          overflow_o;

    always #5 core_clk = ~core_clk;

    caliptra_log_fifo_mux #(
        .NUM_CH (NCH),
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .core_clk     (core_clk),
        .cptra_rst_b  (cptra_rst_b),
        .log_data_i   (log_data_i),
        .log_toggle_i (log_toggle_i),
        .flush_i      (flush_i),
        .clr_drop_i   (clr_drop_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_ch_o     (out_ch_o),
        .fill_o       (fill_o),
        .drop_cnt_o   (drop_cnt_o),
        .overflow_o   (overflow_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue of {ch, data} words the FIFO must hold, in order.
    logic [8:0] exp_q[$];
    bit         model_live = 0;
    bit         m_armed;
    logic [1:0] m_tog;
    bit         m_pend [NCH];
    logic [7:0] m_hold [NCH];
    int         m_drop [NCH];
    bit         m_ovf;
    int         m_last;

    always @(posedge core_clk) begin
        bit m_pop;
        int g;
        bit ev;
        if (!cptra_rst_b) begin
            exp_q.delete();
            m_armed = 0;
            m_tog   = '0;
            m_ovf   = 0;
            m_last  = NCH - 1;
            for (int c = 0; c < NCH; c++) begin
                m_pend[c] = 0;
                m_hold[c] = '0;
                m_drop[c] = 0;
            end
            model_live = 1;
        end else begin
            m_pop = (exp_q.size() != 0) && out_ready_i;
            g = -1;
            if (!flush_i && (exp_q.size() < DEPTH || m_pop)) begin
                for (int i = 1; i <= NCH; i++) begin
                    if (g < 0 && m_pend[(m_last + i) % NCH]) g = (m_last + i) % NCH;
                end
            end
            if (flush_i) begin
                exp_q.delete();
                for (int c = 0; c < NCH; c++) m_pend[c] = 0;
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (g >= 0) begin
                    exp_q.push_back({g[0], m_hold[g]});
                    m_pend[g] = 0;
                    m_last = g;
                end
                for (int c = 0; c < NCH; c++) begin
                    ev = m_armed && (log_toggle_i[c] != m_tog[c]);
                    if (ev) begin
                        // m_pend[c] already reflects a grant this cycle
                        if (m_pend[c]) begin
                            if (!clr_drop_i && m_drop[c] < 65535) m_drop[c]++;
                            if (!clr_drop_i) m_ovf = 1;
                        end else begin
                            m_hold[c] = log_data_i[c*8 +: 8];
                            m_pend[c] = 1;
                        end
                    end
                end
            end
            if (clr_drop_i) begin
                m_ovf = 0;
                for (int c = 0; c < NCH; c++) m_drop[c] = 0;
            end
            m_tog   = log_toggle_i;
            m_armed = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge core_clk) begin
        if (model_live) begin
            chk("valid", {31'd0, out_valid_o}, {31'd0, exp_q.size() != 0});
            chk("fill", {29'd0, fill_o}, 32'(exp_q.size()));
            if (exp_q.size() != 0) begin
                chk("head", {23'd0, out_ch_o, out_data_o}, {23'd0, exp_q[0]});
            end
            chk("drop0", {16'd0, drop_cnt_o[15:0]}, 32'(m_drop[0]));
            chk("drop1", {16'd0, drop_cnt_o[31:16]}, 32'(m_drop[1]));
            chk("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    task automatic toggle(input int c, input logic [7:0] d);
        log_data_i[c*8 +: 8] = d;
        log_toggle_i[c]      = ~log_toggle_i[c];
    endtask

    task automatic lit_head(input string name, input logic [7:0] d, input logic ch);
        chk({name, "_valid"}, {31'd0, out_valid_o}, 32'd1);
        chk({name, "_data"}, {24'd0, out_data_o}, {24'd0, d});
        chk({name, "_ch"}, {31'd0, out_ch_o}, {31'd0, ch});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        cptra_rst_b  = 1'b0;
        log_data_i   = '0;
        log_toggle_i = 2'b01;      // ch0 toggle already high through reset
        flush_i      = 1'b0;
        clr_drop_i   = 1'b0;
        out_ready_i  = 1'b0;
        step(3);
        chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_fill", {29'd0, fill_o}, 32'd0);
        chk("rst_drop", drop_cnt_o, 32'd0);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);

        // Release with toggle held high: arm cycle, no event.
        cptra_rst_b = 1'b1;
        step(3);
        chk("arm_fill", {29'd0, fill_o}, 32'd0);

        // Single word on ch0: visible two edges after the toggle.
        toggle(0, 8'hA5);
        step(1);
        chk("lat1_valid", {31'd0, out_valid_o}, 32'd0);
        step(1);
        lit_head("single", 8'hA5, 1'b0);
        chk("single_fill", {29'd0, fill_o}, 32'd1);

        // Reset mid-operation empties everything.
        cptra_rst_b = 1'b0;
        step(1);
        chk("midrst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("midrst_fill", {29'd0, fill_o}, 32'd0);
        cptra_rst_b = 1'b1;
        step(3);

        // Same-cycle tie: ch0 wins first.
        out_ready_i = 1'b1;
        toggle(0, 8'h11);
        toggle(1, 8'h22);
        step(2);
        lit_head("tie1_a", 8'h11, 1'b0);
        step(1);
        lit_head("tie1_b", 8'h22, 1'b1);
        step(1);
        chk("tie1_empty", {31'd0, out_valid_o}, 32'd0);

        // Lone ch0 word moves priority to ch1.
        toggle(0, 8'h33);
        step(2);
        lit_head("lone", 8'h33, 1'b0);
        step(1);

        // Next tie: ch1 first.
        toggle(0, 8'h44);
        toggle(1, 8'h55);
        step(2);
        lit_head("tie2_a", 8'h55, 1'b1);
        step(1);
        lit_head("tie2_b", 8'h44, 1'b0);
        step(1);
        chk("tie2_empty", {31'd0, out_valid_o}, 32'd0);

        // Six back-to-back words on ch0 with no consumer.
        out_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            toggle(0, 8'h60 + 8'(i));
            step(1);
        end
        chk("ovf_fill", {29'd0, fill_o}, 32'd4);
        chk("ovf_drop0", {16'd0, drop_cnt_o[15:0]}, 32'd1);
        chk("ovf_drop1", {16'd0, drop_cnt_o[31:16]}, 32'd0);
        chk("ovf_flag", {31'd0, overflow_o}, 32'd1);
        lit_head("ovf_head", 8'h60, 1'b0);

        // Pop at full with the pending word pushed in the same cycle.
        out_ready_i = 1'b1;
        step(1);
        chk("full_pp_fill", {29'd0, fill_o}, 32'd4);
        lit_head("full_pp_head", 8'h61, 1'b0);
        for (int j = 2; j <= 4; j++) begin
            step(1);
            lit_head("wrap_head", 8'h60 + 8'(j), 1'b0);
            chk("wrap_fill", {29'd0, fill_o}, 32'(5 - j));
        end
        step(1);
        chk("drain_fill", {29'd0, fill_o}, 32'd0);
        out_ready_i = 1'b0;

        // Flush with traffic in flight.
        toggle(0, 8'h70);
        toggle(1, 8'h71);
        step(3);
        chk("preflush_fill", {29'd0, fill_o}, 32'd2);
        toggle(1, 8'h72);
        flush_i = 1'b1;
        step(1);
        flush_i = 1'b0;
        chk("flush_fill", {29'd0, fill_o}, 32'd0);
        chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
        chk("flush_drop0", {16'd0, drop_cnt_o[15:0]}, 32'd1);
        step(3);
        chk("flush_discard", {29'd0, fill_o}, 32'd0);
        clr_drop_i = 1'b1;
        step(1);
        clr_drop_i = 1'b0;
        chk("clr_drop", drop_cnt_o, 32'd0);
        chk("clr_ovf", {31'd0, overflow_o}, 32'd0);

        // Mixed traffic checked by the model alone.
        for (int i = 0; i < 200; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 2) == 0) toggle(c, 8'($urandom_range(0, 255)));
            end
            out_ready_i = ($urandom_range(0, 2) == 0);
            clr_drop_i  = ($urandom_range(0, 24) == 0);
            flush_i     = ($urandom_range(0, 49) == 0);
            step(1);
        end
        clr_drop_i  = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        step(12);
        chk("final_fill", {29'd0, fill_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
